// File: rtl/ring_token_arbiter_if.sv
// Request/grant bundle between requesters and the ring token arbiter.
// The arbiter takes the slave side; the requester side (or a bench) takes master.
interface ring_token_arbiter_if #(
  parameter int N  = 4,
  parameter int IW = 2
);
  logic          en;
  logic [N-1:0]  req;
  logic          lock;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_id;
  logic [N-1:0]  token;
  logic          preempt;

  modport master (
    output en, req, lock,
    input  gnt, gnt_valid, gnt_id, token, preempt
  );

  modport slave (
    input  en, req, lock,
    output gnt, gnt_valid, gnt_id, token, preempt
  );
endinterface

// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority token, held grants,
// quantum-based preemption and an owner lock. All outputs are registered.
module ring_token_arbiter #(
  parameter int N       = 4,
  parameter int IW      = 2,
  parameter int QUANTUM = 8,
  parameter int CW      = 8
) (
  input logic                 clk,
  input logic                 pset,
  ring_token_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [N-1:0]  ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] QLAST    = CW'(QUANTUM - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  token_q, token_d;
  logic [IW-1:0] id_q, id_d;
  logic          valid_q, valid_d;
  logic          preempt_q, preempt_d;
  logic [CW-1:0] qcnt_q, qcnt_d;

  logic [IW-1:0] tok_idx;
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic          owner_req;
  logic          others_req;
  logic          expired;
  logic [N-1:0]  ring_after_owner;

  always_comb begin
    tok_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (token_q[i]) tok_idx = IW'(i);
    end
  end

  // Scan upward from the token position, wrapping N-1 back to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!win_found && bus.req[(int'(tok_idx) + i) % N]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(tok_idx) + i) % N);
      end
    end
  end

  assign owner_req        = |(bus.req & gnt_q);
  assign others_req       = |(bus.req & ~gnt_q);
  assign expired          = (qcnt_q == QLAST);
  assign ring_after_owner = {gnt_q[N-2:0], gnt_q[N-1]};

  always_ff @(posedge clk) begin
    if (pset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      token_q   <= ONE_HOT0;
      id_q      <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
      qcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      token_q   <= token_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
      qcnt_q    <= qcnt_d;
    end
  end

  // Release takes precedence over preemption when both coincide.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    token_d   = token_q;
    id_d      = id_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;
    qcnt_d    = qcnt_q;

    unique case (state_q)
      IDLE: begin
        gnt_d   = '0;
        id_d    = '0;
        valid_d = 1'b0;
        if (bus.en && win_found) begin
          gnt_d   = ONE_HOT0 << win_idx;
          id_d    = win_idx;
          valid_d = 1'b1;
          qcnt_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          gnt_d   = '0;
          id_d    = '0;
          valid_d = 1'b0;
          token_d = ring_after_owner;
          qcnt_d  = '0;
          state_d = IDLE;
        end else if (!bus.lock && expired && others_req) begin
          gnt_d     = '0;
          id_d      = '0;
          valid_d   = 1'b0;
          token_d   = ring_after_owner;
          qcnt_d    = '0;
          preempt_d = 1'b1;
          state_d   = IDLE;
        end else if (!expired) begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = valid_q;
  assign bus.gnt_id    = id_q;
  assign bus.token     = token_q;
  assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Directed bench for ring_token_arbiter (N=4, QUANTUM=8) with hand-computed
// expectations; each scenario task checks its own outputs inline.
module tb_ring_token_arbiter;

  logic clk;
  logic pset;
  int   checks;
  int   errors;

  ring_token_arbiter_if #(.N(4), .IW(2)) bus ();

  ring_token_arbiter #(
    .N(4), .IW(2), .QUANTUM(8), .CW(8)
  ) dut (
    .clk (clk),
    .pset(pset),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    pset = 1'b1;
    step(1);
    pset = 1'b0;
  endtask

  task automatic test_reset();
    pset     = 1'b1;
    bus.req  = 4'b0000;
    bus.en   = 1'b0;
    bus.lock = 1'b0;
    step(2);
    pset = 1'b0;
    checks++;
    if (bus.token !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL reset_token: got %b expected %b", bus.token, 4'b0001);
    end
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_gnt: got %b expected %b", bus.gnt, 4'b0000);
    end
    checks++;
    if (bus.gnt_id !== 2'd0 || bus.gnt_valid !== 1'b0 || bus.preempt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_id_valid_preempt: got %0d/%b/%b expected 0/0/0",
               bus.gnt_id, bus.gnt_valid, bus.preempt);
    end
  endtask

  // Each owner holds for 3 grant cycles, drops req for one edge, then re-raises.
  task automatic test_rotation();
    logic [3:0] exp_gnt;
    logic [3:0] exp_tok;
    int         o;
    do_reset();
    bus.en   = 1'b1;
    bus.lock = 1'b0;
    bus.req  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      o       = k % 4;
      exp_gnt = 4'b0001 << o;
      exp_tok = {exp_gnt[2:0], exp_gnt[3]};
      step(1);
      checks++;
      if (bus.gnt !== exp_gnt || bus.gnt_id !== 2'(o) || bus.gnt_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rotation_grant_%0d: got gnt=%b id=%0d v=%b expected gnt=%b id=%0d v=1",
                 k, bus.gnt, bus.gnt_id, bus.gnt_valid, exp_gnt, o);
      end
      step(2);
      checks++;
      if (bus.gnt !== exp_gnt) begin
        errors++;
        $display("[TB] FAIL rotation_hold_%0d: got %b expected %b", k, bus.gnt, exp_gnt);
      end
      bus.req[o] = 1'b0;
      step(1);
      checks++;
      if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.token !== exp_tok) begin
        errors++;
        $display("[TB] FAIL rotation_dead_%0d: got gnt=%b v=%b tok=%b expected gnt=0000 v=0 tok=%b",
                 k, bus.gnt, bus.gnt_valid, bus.token, exp_tok);
      end
      bus.req[o] = 1'b1;
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_preempt();
    do_reset();
    bus.en   = 1'b1;
    bus.lock = 1'b0;
    bus.req  = 4'b0011;
    step(1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.gnt !== 4'b0001 || bus.preempt !== 1'b0) begin
        errors++;
        $display("[TB] FAIL preempt_hold_%0d: got gnt=%b pre=%b expected gnt=0001 pre=0",
                 i, bus.gnt, bus.preempt);
      end
      step(1);
    end
    checks++;
    if (bus.gnt !== 4'b0000 || bus.preempt !== 1'b1 || bus.token !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL preempt_pulse: got gnt=%b pre=%b tok=%b expected gnt=0000 pre=1 tok=0010",
               bus.gnt, bus.preempt, bus.token);
    end
    step(1);
    checks++;
    if (bus.gnt !== 4'b0010 || bus.gnt_id !== 2'd1 || bus.preempt !== 1'b0 || bus.token !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL preempt_next_owner: got gnt=%b id=%0d pre=%b tok=%b expected gnt=0010 id=1 pre=0 tok=0010",
               bus.gnt, bus.gnt_id, bus.preempt, bus.token);
    end
    bus.req = 4'b0000;
    step(1);
  endtask

  task automatic test_lock();
    do_reset();
    bus.en   = 1'b1;
    bus.lock = 1'b1;
    bus.req  = 4'b0011;
    step(1);
    for (int i = 1; i <= 12; i++) begin
      checks++;
      if (bus.gnt !== 4'b0001 || bus.preempt !== 1'b0) begin
        errors++;
        $display("[TB] FAIL lock_hold_%0d: got gnt=%b pre=%b expected gnt=0001 pre=0",
                 i, bus.gnt, bus.preempt);
      end
      if (i == 12) bus.lock = 1'b0;
      step(1);
    end
    checks++;
    if (bus.gnt !== 4'b0000 || bus.preempt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lock_release_preempt: got gnt=%b pre=%b expected gnt=0000 pre=1",
               bus.gnt, bus.preempt);
    end
    step(1);
    checks++;
    if (bus.gnt !== 4'b0010 || bus.preempt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lock_next_owner: got gnt=%b pre=%b expected gnt=0010 pre=0",
               bus.gnt, bus.preempt);
    end
    bus.req = 4'b0000;
    step(1);
  endtask

  task automatic test_expired_alone();
    do_reset();
    bus.en   = 1'b1;
    bus.lock = 1'b0;
    bus.req  = 4'b0001;
    step(11);
    checks++;
    if (bus.gnt !== 4'b0001 || bus.preempt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alone_hold: got gnt=%b pre=%b expected gnt=0001 pre=0",
               bus.gnt, bus.preempt);
    end
    bus.req = 4'b0011;
    step(1);
    checks++;
    if (bus.gnt !== 4'b0000 || bus.preempt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL alone_late_preempt: got gnt=%b pre=%b expected gnt=0000 pre=1",
               bus.gnt, bus.preempt);
    end
    bus.req = 4'b0000;
    step(1);
    checks++;
    if (bus.gnt !== 4'b0000 || bus.preempt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alone_pulse_width: got gnt=%b pre=%b expected gnt=0000 pre=0",
               bus.gnt, bus.preempt);
    end
  endtask

  task automatic test_release_at_expiry();
    do_reset();
    bus.en   = 1'b1;
    bus.lock = 1'b0;
    bus.req  = 4'b0011;
    step(8);
    bus.req = 4'b0010;
    step(1);
    checks++;
    if (bus.gnt !== 4'b0000 || bus.preempt !== 1'b0 || bus.token !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL release_expiry: got gnt=%b pre=%b tok=%b expected gnt=0000 pre=0 tok=0010",
               bus.gnt, bus.preempt, bus.token);
    end
    step(1);
    checks++;
    if (bus.gnt !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL release_expiry_next: got %b expected %b", bus.gnt, 4'b0010);
    end
    bus.req = 4'b0000;
    step(1);
  endtask

  task automatic test_wrap_skip();
    do_reset();
    bus.en   = 1'b1;
    bus.lock = 1'b0;
    bus.req  = 4'b0100;
    step(1);
    checks++;
    if (bus.gnt !== 4'b0100 || bus.gnt_id !== 2'd2) begin
      errors++;
      $display("[TB] FAIL wrap_first: got gnt=%b id=%0d expected gnt=0100 id=2", bus.gnt, bus.gnt_id);
    end
    bus.req = 4'b0000;
    step(1);
    checks++;
    if (bus.token !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL wrap_token: got %b expected %b", bus.token, 4'b1000);
    end
    bus.req = 4'b0101;
    step(1);
    checks++;
    if (bus.gnt !== 4'b0001 || bus.gnt_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL wrap_winner: got gnt=%b id=%0d expected gnt=0001 id=0", bus.gnt, bus.gnt_id);
    end
    bus.req = 4'b0000;
    step(1);
  endtask

  task automatic test_mid_reset_enable();
    do_reset();
    bus.en   = 1'b1;
    bus.lock = 1'b1;
    bus.req  = 4'b0100;
    step(2);
    pset    = 1'b1;
    bus.req = 4'b1111;
    step(1);
    pset = 1'b0;
    checks++;
    if (bus.gnt !== 4'b0000 || bus.token !== 4'b0001 || bus.gnt_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset: got gnt=%b tok=%b v=%b expected gnt=0000 tok=0001 v=0",
               bus.gnt, bus.token, bus.gnt_valid);
    end
    bus.en   = 1'b0;
    bus.lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if (bus.gnt !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL en_low_idle_%0d: got %b expected %b", i, bus.gnt, 4'b0000);
      end
    end
    bus.en = 1'b1;
    step(1);
    checks++;
    if (bus.gnt !== 4'b0001 || bus.gnt_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL en_high_grant: got gnt=%b id=%0d expected gnt=0001 id=0", bus.gnt, bus.gnt_id);
    end
    bus.en = 1'b0;
    step(1);
    checks++;
    if (bus.gnt !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL en_low_hold: got %b expected %b", bus.gnt, 4'b0001);
    end
    bus.req = 4'b0000;
    step(1);
    checks++;
    if (bus.gnt !== 4'b0000 || bus.token !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL en_low_release: got gnt=%b tok=%b expected gnt=0000 tok=0010", bus.gnt, bus.token);
    end
    bus.req = 4'b1111;
    step(1);
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL en_low_no_new_grant: got %b expected %b", bus.gnt, 4'b0000);
    end
    bus.req = 4'b0000;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    pset     = 1'b1;
    bus.en   = 1'b0;
    bus.req  = 4'b0000;
    bus.lock = 1'b0;
    test_reset();
    test_rotation();
    test_preempt();
    test_lock();
    test_expired_alone();
    test_release_at_expiry();
    test_wrap_skip();
    test_mid_reset_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
